// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between two requesters: a reset-time init
// sweep of every register, then round-robin arbitration with valid/grant handshakes.
module rf_write_arbiter #(
  parameter int unsigned   NREG         = 32,
  parameter int unsigned   AW           = 5,
  parameter int unsigned   DW           = 32,
  parameter logic [DW-1:0] INIT_VAL     = '0,
  parameter bit            ZERO_PROTECT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_wreq,
  input  logic [AW-1:0] m0_wn,
  input  logic [DW-1:0] m0_wd,
  output logic          m0_wgnt,
  input  logic          m1_wreq,
  input  logic [AW-1:0] m1_wn,
  input  logic [DW-1:0] m1_wd,
  output logic          m1_wgnt,
  output logic          init_busy,
  output logic          rf_w,
  output logic [AW-1:0] rf_wn,
  output logic [DW-1:0] rf_wd
);

  typedef enum logic {ST_INIT, ST_ARB} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rr_q, rr_d;       // 0: m0 wins the next conflict, 1: m1 wins
  logic          w_d;
  logic [AW-1:0] wn_d;
  logic [DW-1:0] wd_d;
  logic          busy_d;
  logic          gnt0, gnt1;
  logic [AW-1:0] sel_wn;
  logic [DW-1:0] sel_wd;

  // State register and registered rf-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      rf_w      <= 1'b0;
      rf_wn     <= '0;
      rf_wd     <= '0;
      init_busy <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      rf_w      <= w_d;
      rf_wn     <= wn_d;
      rf_wd     <= wd_d;
      init_busy <= busy_d;
    end
  end

  // Grants are combinational from live requests so a transfer needs no extra cycle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n && (state_q == ST_ARB)) begin
      if (m0_wreq && (!m1_wreq || !rr_q)) begin
        gnt0 = 1'b1;
      end else if (m1_wreq) begin
        gnt1 = 1'b1;
      end
    end
  end

  assign m0_wgnt = gnt0;
  assign m1_wgnt = gnt1;
  assign sel_wn  = gnt1 ? m1_wn : m0_wn;
  assign sel_wd  = gnt1 ? m1_wd : m0_wd;

  // Next-state: sweep counter during init, winner capture during arbitration
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    w_d     = 1'b0;
    wn_d    = rf_wn;
    wd_d    = rf_wd;
    busy_d  = init_busy;
    case (state_q)
      ST_INIT: begin
        w_d   = 1'b1;
        wn_d  = cnt_q;
        wd_d  = INIT_VAL;
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = ST_ARB;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_ARB: begin
        if (gnt0 || gnt1) begin
          rr_d = gnt0;
          wn_d = sel_wn;
          wd_d = sel_wd;
          w_d  = !(ZERO_PROTECT && (sel_wn == '0));
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic, all checked
// every cycle against a transaction-level model of the init sweep and round-robin.
module tb_rf_write_arbiter;

  localparam int unsigned   AW   = 5;
  localparam int unsigned   DW   = 32;
  localparam int unsigned   NREG = 32;
  localparam logic [DW-1:0] IV   = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_wreq = 1'b0, m1_wreq = 1'b0;
  logic [AW-1:0] m0_wn = '0, m1_wn = '0;
  logic [DW-1:0] m0_wd = '0, m1_wd = '0;
  logic          m0_wgnt, m1_wgnt, init_busy, rf_w;
  logic [AW-1:0] rf_wn;
  logic [DW-1:0] rf_wd;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(
    .NREG(NREG), .AW(AW), .DW(DW), .INIT_VAL(IV), .ZERO_PROTECT(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_wreq(m0_wreq), .m0_wn(m0_wn), .m0_wd(m0_wd), .m0_wgnt(m0_wgnt),
    .m1_wreq(m1_wreq), .m1_wn(m1_wn), .m1_wd(m1_wd), .m1_wgnt(m1_wgnt),
    .init_busy(init_busy), .rf_w(rf_w), .rf_wn(rf_wn), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  // Model: sweep position, who wins the next tie, and what rf must see next cycle
  bit            seen_rst = 1'b0;
  bit            m_init = 1'b1;
  int            m_cnt = 0;
  bit            m_pref = 1'b0;
  bit            e_w = 1'b0;
  logic [AW-1:0] e_wn = '0;
  logic [DW-1:0] e_wd = '0;
  bit            e_busy = 1'b1;
  logic [DW-1:0] model_rf [NREG];
  logic [DW-1:0] dut_rf   [NREG];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void exp_grants(output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n === 1'b1 && !m_init) begin
      if (m0_wreq && m1_wreq) begin
        g0 = (m_pref == 1'b0);
        g1 = (m_pref == 1'b1);
      end else begin
        g0 = m0_wreq;
        g1 = m1_wreq;
      end
    end
  endfunction

  always @(posedge clk) begin : model
    bit g0, g1;
    exp_grants(g0, g1);
    if (rst_n !== 1'b1) begin
      seen_rst = 1'b1;
      m_init = 1'b1; m_cnt = 0; m_pref = 1'b0;
      e_w = 1'b0; e_wn = '0; e_wd = '0; e_busy = 1'b1;
    end else if (m_init) begin
      e_w  = 1'b1;
      e_wn = AW'(m_cnt);
      e_wd = IV;
      model_rf[m_cnt] = IV;
      m_cnt++;
      if (m_cnt == int'(NREG)) begin
        m_init = 1'b0;
        e_busy = 1'b0;
      end
    end else if (g0 || g1) begin
      e_wn   = g0 ? m0_wn : m1_wn;
      e_wd   = g0 ? m0_wd : m1_wd;
      e_w    = (e_wn != '0);
      if (e_w) model_rf[e_wn] = e_wd;
      m_pref = g0;
    end else begin
      e_w = 1'b0;
    end
  end

  // Compare every cycle at mid-period, then mirror what rf itself would store
  always @(negedge clk) begin : compare
    bit g0, g1;
    if (seen_rst) begin
      exp_grants(g0, g1);
      chk("m0_wgnt", m0_wgnt, g0);
      chk("m1_wgnt", m1_wgnt, g1);
      chk("init_busy", init_busy, e_busy);
      chk("rf_w", rf_w, e_w);
      chk("rf_wn", rf_wn, e_wn);
      chk("rf_wd", rf_wd, e_wd);
      if (rf_w === 1'b1) dut_rf[rf_wn] = rf_wd;
    end
  end

  task automatic tick(output bit f0, output bit f1);
    @(posedge clk);
    f0 = rst_n && m0_wreq && m0_wgnt;
    f1 = rst_n && m1_wreq && m1_wgnt;
    #1;
  endtask

  task automatic wait_any(input int maxc, output int who, output int n);
    bit f0, f1;
    who = -1;
    n = 0;
    while (who < 0 && n < maxc) begin
      tick(f0, f1);
      n++;
      if (f0) who = 0;
      else if (f1) who = 1;
    end
    if (who < 0) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout actual=none required=grant within %0d cycles", maxc);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit f0, f1;
    int who, n, bad, c0, c1;
    int log_q[$];
    for (int i = 0; i < int'(NREG); i++) begin
      model_rf[i] = '0;
      dut_rf[i]   = '0;
    end

    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", init_busy, 1);
    chk("reset_rf_w", rf_w, 0);

    // Request held from reset release is granted only after the full sweep
    m0_wreq = 1'b1; m0_wn = AW'(7); m0_wd = 32'h77;
    rst_n = 1'b1;
    wait_any(100, who, n);
    chk("init_hold_who", who, 0);
    chk("init_hold_latency", n, 33);
    m0_wreq = 1'b0;
    bad = 0;
    for (int i = 0; i < int'(NREG); i++) if (dut_rf[i] !== IV) bad++;
    chk("sweep_all_init_val", bad, 0);
    tick(f0, f1); tick(f0, f1);
    chk("init_hold_reg7", dut_rf[7], 32'h77);

    // Single master
    m0_wreq = 1'b1; m0_wn = AW'(5); m0_wd = 32'd25;
    wait_any(10, who, n);
    chk("single_latency", n, 1);
    chk("single_rf_wn", rf_wn, 5);
    m0_wreq = 1'b0;
    tick(f0, f1); tick(f0, f1);
    chk("single_reg5", dut_rf[5], 32'd25);

    // Conflict: four writes each, must alternate
    m0_wreq = 1'b1; m0_wn = AW'(3); m0_wd = 32'd9;
    m1_wreq = 1'b1; m1_wn = AW'(4); m1_wd = 32'd16;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 8; k++) begin
      tick(f0, f1);
      if (f0) begin c0++; log_q.push_back(0); if (c0 == 4) m0_wreq = 1'b0; end
      if (f1) begin c1++; log_q.push_back(1); if (c1 == 4) m1_wreq = 1'b0; end
    end
    chk("conflict_xfers", log_q.size(), 8);
    bad = 0;
    for (int i = 1; i < log_q.size(); i++) if (log_q[i] == log_q[i-1]) bad++;
    chk("conflict_alternate", bad, 0);
    chk("conflict_m0_count", c0, 4);
    m0_wreq = 1'b0; m1_wreq = 1'b0;

    // Zero protect
    m1_wreq = 1'b1; m1_wn = '0; m1_wd = 32'd77;
    wait_any(10, who, n);
    chk("zero_who", who, 1);
    chk("zero_rf_w", rf_w, 0);
    m1_wreq = 1'b0;
    tick(f0, f1); tick(f0, f1);
    chk("zero_reg0", dut_rf[0], IV);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      if (!m0_wreq && $urandom_range(0, 1) == 0) begin
        m0_wreq = 1'b1; m0_wn = AW'($urandom_range(0, 31)); m0_wd = $urandom;
      end
      if (!m1_wreq && $urandom_range(0, 1) == 0) begin
        m1_wreq = 1'b1; m1_wn = AW'($urandom_range(0, 31)); m1_wd = $urandom;
      end
      tick(f0, f1);
      if (f0) m0_wreq = 1'b0;
      if (f1) m1_wreq = 1'b0;
    end
    m0_wreq = 1'b0; m1_wreq = 1'b0;
    repeat (2) tick(f0, f1);

    // Reset at sweep count 10
    rst_n = 1'b0; tick(f0, f1);
    rst_n = 1'b1;
    repeat (10) tick(f0, f1);
    chk("midsweep_pre_wn", rf_wn, 9);
    rst_n = 1'b0; tick(f0, f1);
    chk("midsweep_rf_w", rf_w, 0);
    chk("midsweep_busy", init_busy, 1);
    rst_n = 1'b1;

    // Both held through init: m0 wins first, then reset mid-arbitration with m1 preferred
    m0_wreq = 1'b1; m0_wn = AW'(9);  m0_wd = 32'hA1;
    m1_wreq = 1'b1; m1_wn = AW'(10); m1_wd = 32'hB2;
    wait_any(100, who, n);
    chk("restart_first_who", who, 0);
    chk("restart_latency", n, 33);
    tick(f0, f1); tick(f0, f1);
    rst_n = 1'b0; tick(f0, f1);
    chk("midarb_rf_w", rf_w, 0);
    chk("midarb_grant_in_reset", f0 | f1, 0);
    rst_n = 1'b1;
    wait_any(100, who, n);
    chk("midarb_rr_reset_who", who, 0);
    m0_wreq = 1'b0; m1_wreq = 1'b0;
    repeat (40) tick(f0, f1);

    bad = 0;
    for (int i = 0; i < int'(NREG); i++) if (dut_rf[i] !== model_rf[i]) bad++;
    chk("final_rf_contents", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sequences and shares the single write port (wn/wd/w) of the 32x32 register file `rf` between two requesters, e.g. pipeline writeback (m0) and loader/debug port (m1).
- After reset it first runs an init sweep that writes INIT_VAL to every register.
- It then grants write requests round-robin with valid/grant handshakes.
- Outputs drive `rf` write inputs directly; read ports are untouched.

Parameters:
NREG, 32, number of registers swept during init (must equal 2**AW)
AW, 5, register address width
DW, 32, data width
INIT_VAL, 0, value written to each register during init sweep
ZERO_PROTECT, 1, when 1 granted writes to register 0 are consumed but not issued to rf

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
m0_wreq  in  1  master 0 write request (held until granted)
m0_wn  in  AW  master 0 destination register
m0_wd  in  DW  master 0 write data
m0_wgnt  out  1  master 0 grant; transfer occurs on edge where m0_wreq&&m0_wgnt
m1_wreq  in  1  master 1 write request
m1_wn  in  AW  master 1 destination register
m1_wd  in  DW  master 1 write data
m1_wgnt  out  1  master 1 grant
init_busy  out  1  high while init sweep is running
rf_w  out  1  registered write enable to rf
rf_wn  out  AW  registered write address to rf
rf_wd  out  DW  registered write data to rf

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=INIT, cnt=0, rr_ptr=0 (m0 preferred next).
  - rf_w=0, rf_wn=0, rf_wd=0, init_busy=1.
  - Grants 0 while rst_n is low.
  - Reset applies mid-sweep or mid-arbitration: any pending transfer is dropped and the sweep restarts at register 0.
- FSM states: INIT, ARB.
- INIT:
  - Each cycle registers rf_w=1, rf_wn=cnt, rf_wd=INIT_VAL, then cnt++.
  - After the edge issuing cnt=NREG-1, go to ARB; init_busy falls in that same edge.
  - Exactly NREG consecutive cycles of rf_w=1, addresses 0..NREG-1 ascending, including register 0 (ZERO_PROTECT ignored in INIT).
  - m0_wgnt=m1_wgnt=0 throughout; requests are held, not lost.
- ARB, grant logic (combinational, from current reqs and rr_ptr):
  - Only m0 requests -> m0_wgnt=1.
  - Only m1 requests -> m1_wgnt=1.
  - Both request -> grant the master selected by rr_ptr.
  - Neither requests -> both grants 0.
  - At most one grant high in any cycle.
- ARB, on a transfer edge:
  - rr_ptr flips to the other master, so the loser of a conflict wins next.
  - rf_wn/rf_wd capture the winner's wn/wd.
  - rf_w=1, except rf_w=0 when ZERO_PROTECT=1 and wn=0.
- ARB, no transfer: rf_w=0 next cycle; rf_wn/rf_wd hold previous values; rr_ptr holds.
- Latency: request granted in cycle N -> rf_w/wn/wd valid during cycle N+1 -> rf writes at end of N+1.
- Throughput: one write per cycle. Under continuous dual requests, grants strictly alternate m0,m1,m0,...
- A master may change wn/wd only after its transfer edge.
- rf_w is high for exactly one cycle per accepted transfer; no duplicates and no dropped accepted requests (apart from $0 suppression).

Test Plan:
- Reset sweep: rst_n low 2 cycles then high, INIT_VAL=32'hDEAD_BEEF -> rf_w=1 for exactly 32 cycles, rf_wn 0..31, rf_wd=DEADBEEF, init_busy falls after wn=31, grants 0 throughout; reading all 32 regs returns DEADBEEF.
- Single master: after init, m0 writes wn=5 wd=25 -> m0_wgnt same cycle, rf_w=1 wn=5 wd=25 next cycle; rd1 with rn1=5 returns 25 afterwards.
- Conflict/fairness: m0 (wn=3,wd=9) and m1 (wn=4,wd=16) both request continuously for 4 writes each -> grants m0,m1,m0,m1,... never both high; 8 rf_w pulses in 8 cycles.
- Zero protect: m1 writes wn=0 wd=77 -> m1_wgnt=1, rf_w stays 0; register 0 remains INIT_VAL (0 with default).
- Requests during init: m0_wreq held from reset release -> no grant until init_busy=0, then granted first ARB cycle; write lands after all 32 init writes.
- Reset mid-operation: assert rst_n low at sweep cnt=10 and again during dual-request ARB -> rf_w=0 next cycle, sweep restarts at wn=0, rr_ptr back to m0.
